duty_select_ctrl: RTL

Front-panel input stage of the RGB LED driver: conditions three raw push-buttons and maintains the user-selected colour channel and the three 0–10 duty-cycle settings. It sits directly upstream of the display multiplexer and the PWM generators. `H1` and the `*_DUTY` outputs drive both stages unchanged. All timing is qualified by the shared slow tick `CE_IN`.

---
 rtl/duty_select_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/duty_select_ctrl.sv
// duty_select_ctrl: front-panel button conditioning, colour-channel selection
// and saturating 0..DUTY_MAX duty settings for the RGB LED driver.
module duty_select_ctrl #(
    parameter int unsigned DEB_TICKS    = 4,
    parameter int unsigned REPEAT_TICKS = 50,
    parameter int unsigned DUTY_MAX     = 10,
    parameter int unsigned DUTY_RST     = 0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE_IN,
    input  logic       BTN_SEL,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    output logic [1:0] H1,
    output logic [3:0] RED_DUTY,
    output logic [3:0] GREEN_DUTY,
    output logic [3:0] BLUE_DUTY,
    output logic       CHANGED
);

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_RED   = 2'b01,
        SEL_GREEN = 2'b10,
        SEL_BLUE  = 2'b11
    } sel_state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS - 1);
    localparam logic [7:0] REP_LAST = 8'(REPEAT_TICKS - 1);
    localparam logic [3:0] DMAX     = 4'(DUTY_MAX);
    localparam logic [3:0] DRST     = 4'(DUTY_RST);

    // Button index: 0 SEL, 1 UP, 2 DOWN
    logic [2:0] raw, sync1, sync2, stable, stable_prev, press;
    logic [3:0] deb_cnt [3];
    // Hold counters: 0 UP, 1 DOWN
    logic [7:0] hold_cnt [2];
    logic [1:0] rep;
    logic       up_step, dn_step, do_inc, do_dec;
    logic [3:0] cur_duty, new_duty;
    sel_state_t state, next_sel;

    assign raw = {BTN_DOWN, BTN_UP, BTN_SEL};

    // Two-flop synchroniser for the raw buttons
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level after DEB_TICKS consecutive mismatching ticks
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            stable      <= '0;
            stable_prev <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            stable_prev <= stable;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (CE_IN) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    assign press = stable & ~stable_prev;

    // Hold counters for UP/DOWN auto-repeat, restarted by each press
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int unsigned i = 0; i < 2; i++) hold_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (press[i+1] || !stable[i+1]) begin
                    hold_cnt[i] <= '0;
                end else if (CE_IN) begin
                    if (hold_cnt[i] == REP_LAST) hold_cnt[i] <= '0;
                    else                         hold_cnt[i] <= hold_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Repeat events, step qualification and next-value computation
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            rep[i] = stable[i+1] && !press[i+1] && CE_IN && (hold_cnt[i] == REP_LAST);
        end
        up_step = press[1] | rep[0];
        dn_step = press[2] | rep[1];

        case (state)
            SEL_RED:   cur_duty = RED_DUTY;
            SEL_GREEN: cur_duty = GREEN_DUTY;
            SEL_BLUE:  cur_duty = BLUE_DUTY;
            default:   cur_duty = '0;
        endcase

        do_inc = up_step && !dn_step && (state != SEL_NONE) && (cur_duty < DMAX);
        do_dec = dn_step && !up_step && (state != SEL_NONE) && (cur_duty != 4'd0);

        if (do_inc)      new_duty = cur_duty + 4'd1;
        else if (do_dec) new_duty = cur_duty - 4'd1;
        else             new_duty = cur_duty;

        case (state)
            SEL_NONE:  next_sel = SEL_RED;
            SEL_RED:   next_sel = SEL_GREEN;
            SEL_GREEN: next_sel = SEL_BLUE;
            default:   next_sel = SEL_RED;
        endcase
    end

    // Select FSM and duty registers; a SEL press pre-empts any UP/DOWN step
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state      <= SEL_NONE;
            RED_DUTY   <= DRST;
            GREEN_DUTY <= DRST;
            BLUE_DUTY  <= DRST;
            CHANGED    <= 1'b0;
        end else begin
            CHANGED <= 1'b0;
            if (press[0]) begin
                state   <= next_sel;
                CHANGED <= 1'b1;
            end else if (do_inc || do_dec) begin
                case (state)
                    SEL_RED:   RED_DUTY   <= new_duty;
                    SEL_GREEN: GREEN_DUTY <= new_duty;
                    SEL_BLUE:  BLUE_DUTY  <= new_duty;
                    default:   ;
                endcase
                CHANGED <= 1'b1;
            end
        end
    end

    assign H1 = state;

endmodule
